// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with RX FIFO and TX holding register; define SPI_TARGET_ECHO_EN to echo the last received byte on TX underflow
module spi_target #(
  parameter int RxFifoDepth = 4,
  parameter int SyncStages = 2
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_rx_i,
  output logic       spi_tx_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       rx_overflow_o,
  output logic       tx_underflow_o
);
  localparam int AW = $clog2(RxFifoDepth);
  localparam logic IDLE = 1'b0;
  localparam logic ACTIVE = 1'b1;

  logic [SyncStages-1:0][2:0] sy;
  logic sck_s, cs_s, mosi_s, sck_d, cs_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic state, byte_done, push_req, tx_load, tx_shift_en, bit_en;
  logic [2:0] cnt;
  logic [7:0] rx_shift, tx_shift, hold, uf_byte;
  logic hold_full;
  logic [7:0] mem [RxFifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, push, pop;

  assign {mosi_s, cs_s, sck_s} = sy[SyncStages-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni)
    if (!rst_sys_ni) begin
      for (int i = 0; i < SyncStages; i++) sy[i] <= 3'b010;
      sck_d <= 1'b0;
      cs_d <= 1'b1;
    end else begin
      sy[0] <= {spi_rx_i, spi_cs_ni, spi_sck_i};
      for (int i = 1; i < SyncStages; i++) sy[i] <= sy[i-1];
      sck_d <= sck_s;
      cs_d <= cs_s;
    end

  // a CS rise takes priority over any SCK edge seen in the same cycle
  assign bit_en = (state == ACTIVE) & ~cs_rise & sck_rise;
  assign tx_load = (state == IDLE) ? cs_fall : ~cs_rise & sck_fall & byte_done;
  assign tx_shift_en = (state == ACTIVE) & ~cs_rise & sck_fall & ~byte_done;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni)
    if (!rst_sys_ni) begin
      state <= IDLE;
      cnt <= 3'd0;
      rx_shift <= 8'h00;
      byte_done <= 1'b0;
      push_req <= 1'b0;
    end else begin
      push_req <= bit_en & (cnt == 3'd7);
      if (state == IDLE) begin
        if (cs_fall) begin
          state <= ACTIVE;
          cnt <= 3'd0;
          byte_done <= 1'b0;
        end
      end else if (cs_rise) begin
        state <= IDLE;
        cnt <= 3'd0;
        byte_done <= 1'b0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) byte_done <= 1'b1;
      end else if (sck_fall) begin
        byte_done <= 1'b0;
      end
    end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni)
    if (!rst_sys_ni) begin
      tx_shift <= 8'h00;
      hold <= 8'h00;
      hold_full <= 1'b0;
      tx_underflow_o <= 1'b0;
    end else begin
      tx_underflow_o <= tx_load & ~hold_full;
      if (tx_load) tx_shift <= hold_full ? hold : uf_byte;
      else if (tx_shift_en) tx_shift <= {tx_shift[6:0], 1'b0};
      if (tx_valid_i & ~hold_full) begin
        hold <= tx_data_i;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
    end

  assign tx_ready_o = ~hold_full;
  assign spi_tx_o = (state == ACTIVE) ? tx_shift[7] : 1'b1;

  // rx_shift still holds the completed byte in the cycle after the 8th rise
  assign full = count == (AW+1)'(RxFifoDepth);
  assign pop = rx_valid_o & rx_ready_i;
  assign push = push_req & (~full | pop);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni)
    if (!rst_sys_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rx_overflow_o <= 1'b0;
    end else begin
      rx_overflow_o <= push_req & full & ~pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end

  always_ff @(posedge clk_sys_i)
    if (push) mem[wr_ptr] <= rx_shift;

  assign rx_valid_o = count != '0;
  assign rx_data_o = rx_valid_o ? mem[rd_ptr] : 8'h00;

`ifdef SPI_TARGET_ECHO_EN
  logic [7:0] last_rx;
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni)
    if (!rst_sys_ni) last_rx <= 8'h00;
    else if (push) last_rx <= rx_shift;
  assign uf_byte = last_rx;
`else
  assign uf_byte = 8'hFF;
`endif
endmodule
